// File: rtl/btn_pkg.sv
// Shared types and default timing for the button event generator.
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_PRESSED,
    BTN_REPEAT
  } btn_state_t;

  localparam int HOLD_CYCLES_DEF   = 50_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_gen_if.sv
// Button levels in, event pulses out; the generator uses the slave side.
interface btn_event_gen_if #(
  parameter int N_BTN = 4
) ();

  logic [N_BTN-1:0] btn_in;
  logic             repeat_en;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;
  logic [N_BTN-1:0] repeat_pulse;
  logic [N_BTN-1:0] held;

  modport master (
    output btn_in, repeat_en,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  btn_in, repeat_en,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, held
  );

endinterface

// File: rtl/btn_event_ch.sv
// One button channel: press/release/long-press/auto-repeat pulse generator.
//  state        | meaning
//  BTN_IDLE     | button released, waiting for a press
//  BTN_PRESSED  | held, counting towards the long-press threshold
//  BTN_REPEAT   | long-press reached, counting repeat periods
module btn_event_ch
  import btn_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic             press_d, release_d, long_d, repeat_d, held_d;

  // The FSM state doubles as the previous sampled level, so edge detection
  // needs no separate btn_q flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= BTN_IDLE;
      count         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_d;
      count         <= count_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
    end
  end

  always_comb begin
    state_d = state;
    count_d = count;
    case (state)
      BTN_IDLE: begin
        if (btn_in) begin
          state_d = BTN_PRESSED;
          count_d = '0;
        end
      end
      BTN_PRESSED: begin
        if (!btn_in) begin
          state_d = BTN_IDLE;
          count_d = '0;
        end else if (count == HOLD_LAST) begin
          state_d = BTN_REPEAT;
          count_d = '0;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
      BTN_REPEAT: begin
        if (!btn_in) begin
          state_d = BTN_IDLE;
          count_d = '0;
        end else if (count == REPEAT_LAST) begin
          count_d = '0;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
      default: begin
        state_d = BTN_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Release takes priority over a threshold hit on the same edge.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state)
      BTN_IDLE: begin
        press_d  = btn_in;
        repeat_d = btn_in;
      end
      BTN_PRESSED: begin
        if (!btn_in) begin
          release_d = 1'b1;
        end else if (count == HOLD_LAST) begin
          long_d   = 1'b1;
          repeat_d = repeat_en;
        end
      end
      BTN_REPEAT: begin
        if (!btn_in) begin
          release_d = 1'b1;
        end else if (count == REPEAT_LAST) begin
          repeat_d = repeat_en;
        end
      end
      default: begin
        press_d = 1'b0;
      end
    endcase
    held_d = (state_d != BTN_IDLE) || release_d;
  end

endmodule

// File: rtl/btn_event_gen.sv
// N_BTN independent button channels sharing one repeat enable; wiring only.
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst,
  btn_event_gen_if.slave bus
);

  logic [N_BTN-1:0] press_v, release_v, long_v, repeat_v, held_v;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_event_ch #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (bus.btn_in[i]),
      .repeat_en    (bus.repeat_en),
      .press_pulse  (press_v[i]),
      .release_pulse(release_v[i]),
      .long_pulse   (long_v[i]),
      .repeat_pulse (repeat_v[i]),
      .held         (held_v[i])
    );
  end

  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.long_pulse    = long_v;
  assign bus.repeat_pulse  = repeat_v;
  assign bus.held          = held_v;

endmodule
